// File: rtl/network_input_queue_pkg.sv
// Shared constants and FSM encoding for the network input queue slice.
// Queue RAM word layout: [56:48] next pointer, [47:0] descriptor.
package network_input_queue_pkg;

    localparam int NQ       = 8;
    localparam int QID_W    = 3;
    localparam int ADDR_W   = 9;
    localparam int DESC_W   = 48;
    localparam int WORD_W   = ADDR_W + DESC_W;
    localparam int HEAD_W   = NQ * ADDR_W;

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        WRITE_S = 2'd1,
        LINK_S  = 2'd2
    } nqi_state_t;

endpackage

// File: rtl/network_input_queue_ptr_table.sv
// Per-queue head/tail/empty/tail-descriptor state.
// Within a cycle the scheduler's dequeue is applied before the link update.
module nqi_ptr_table
    import network_input_queue_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_dequeue,
    input  logic [QID_W-1:0]    iv_dequeue_qid,
    input  logic [ADDR_W-1:0]   iv_dequeue_next,
    input  logic                i_link,
    input  logic [QID_W-1:0]    iv_link_qid,
    input  logic [ADDR_W-1:0]   iv_link_bufid,
    input  logic [DESC_W-1:0]   iv_link_desc,
    output logic                o_link_empty,
    output logic [ADDR_W-1:0]   ov_link_tail,
    output logic [DESC_W-1:0]   ov_link_tail_desc,
    output logic [NQ-1:0]       ov_queue_empty,
    output logic [HEAD_W-1:0]   ov_head_ptr,
    output logic                o_dequeue_err
);

    logic [ADDR_W-1:0] head_q [NQ];
    logic [ADDR_W-1:0] tail_q [NQ];
    logic [DESC_W-1:0] tdesc_q [NQ];
    logic [NQ-1:0]     empty_q;

    logic [ADDR_W-1:0] head_mid [NQ];
    logic [NQ-1:0]     empty_mid;
    logic              err_d;

    logic [ADDR_W-1:0] head_d [NQ];
    logic [ADDR_W-1:0] tail_d [NQ];
    logic [DESC_W-1:0] tdesc_d [NQ];
    logic [NQ-1:0]     empty_d;

    always_comb begin
        head_mid  = head_q;
        empty_mid = empty_q;
        err_d     = 1'b0;
        if (i_dequeue) begin
            if (empty_q[iv_dequeue_qid])
                err_d = 1'b1;
            else if (head_q[iv_dequeue_qid] == tail_q[iv_dequeue_qid])
                empty_mid[iv_dequeue_qid] = 1'b1;
            else
                head_mid[iv_dequeue_qid] = iv_dequeue_next;
        end
    end

    // Link sees the post-dequeue view, so a queue drained this cycle restarts at the new entry.
    assign o_link_empty      = empty_mid[iv_link_qid];
    assign ov_link_tail      = tail_q[iv_link_qid];
    assign ov_link_tail_desc = tdesc_q[iv_link_qid];

    always_comb begin
        head_d  = head_mid;
        empty_d = empty_mid;
        tail_d  = tail_q;
        tdesc_d = tdesc_q;
        if (i_link) begin
            if (empty_mid[iv_link_qid]) begin
                head_d[iv_link_qid]  = iv_link_bufid;
                empty_d[iv_link_qid] = 1'b0;
            end
            tail_d[iv_link_qid]  = iv_link_bufid;
            tdesc_d[iv_link_qid] = iv_link_desc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q        <= '{default: '0};
            tail_q        <= '{default: '0};
            tdesc_q       <= '{default: '0};
            empty_q       <= '1;
            o_dequeue_err <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            tdesc_q       <= tdesc_d;
            empty_q       <= empty_d;
            o_dequeue_err <= err_d;
        end
    end

    assign ov_queue_empty = empty_q;

    always_comb begin
        ov_head_ptr = '0;
        for (int unsigned q = 0; q < NQ; q++)
            ov_head_ptr[q*ADDR_W +: ADDR_W] = head_q[q[QID_W-1:0]];
    end

endmodule

// File: rtl/network_input_queue.sv
// Descriptor intake FSM: writes each entry at its buffer ID, then links it
// behind the current tail of its priority queue in the shared queue RAM.
module network_input_queue
    import network_input_queue_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DESC_W-1:0]   iv_descriptor,
    input  logic [QID_W-1:0]    iv_descriptor_qid,
    input  logic [ADDR_W-1:0]   iv_descriptor_bufid,
    input  logic                i_descriptor_wr,
    output logic                o_descriptor_ready,
    output logic [WORD_W-1:0]   ov_queue_wdata,
    output logic [ADDR_W-1:0]   ov_queue_waddr,
    output logic                o_queue_wr,
    input  logic                i_dequeue,
    input  logic [QID_W-1:0]    iv_dequeue_qid,
    input  logic [ADDR_W-1:0]   iv_dequeue_next,
    output logic [NQ-1:0]       ov_queue_empty,
    output logic [HEAD_W-1:0]   ov_head_ptr,
    output logic                o_dequeue_err
);

    nqi_state_t        state_q, state_d;
    logic [DESC_W-1:0] desc_q;
    logic [QID_W-1:0]  qid_q;
    logic [ADDR_W-1:0] bufid_q;

    logic              ready_d;
    logic              wr_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [WORD_W-1:0] wdata_d;
    logic              link_en;

    logic              link_empty;
    logic [ADDR_W-1:0] link_tail;
    logic [DESC_W-1:0] link_tail_desc;

    nqi_ptr_table u_ptr_table (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_dequeue         (i_dequeue),
        .iv_dequeue_qid    (iv_dequeue_qid),
        .iv_dequeue_next   (iv_dequeue_next),
        .i_link            (link_en),
        .iv_link_qid       (qid_q),
        .iv_link_bufid     (bufid_q),
        .iv_link_desc      (desc_q),
        .o_link_empty      (link_empty),
        .ov_link_tail      (link_tail),
        .ov_link_tail_desc (link_tail_desc),
        .ov_queue_empty    (ov_queue_empty),
        .ov_head_ptr       (ov_head_ptr),
        .o_dequeue_err     (o_dequeue_err)
    );

    // Outputs are registered: each state's RAM action appears right after its own clock edge.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        wr_d    = 1'b0;
        waddr_d = ov_queue_waddr;
        wdata_d = ov_queue_wdata;
        link_en = 1'b0;
        case (state_q)
            IDLE_S: begin
                ready_d = 1'b1;
                if (i_descriptor_wr) begin
                    state_d = WRITE_S;
                    ready_d = 1'b0;
                end
            end
            WRITE_S: begin
                wr_d    = 1'b1;
                waddr_d = bufid_q;
                wdata_d = {{ADDR_W{1'b0}}, desc_q};
                state_d = LINK_S;
            end
            LINK_S: begin
                link_en = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE_S;
                if (!link_empty) begin
                    wr_d    = 1'b1;
                    waddr_d = link_tail;
                    wdata_d = {bufid_q, link_tail_desc};
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE_S;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q            <= IDLE_S;
            o_descriptor_ready <= 1'b1;
            o_queue_wr         <= 1'b0;
            ov_queue_waddr     <= '0;
            ov_queue_wdata     <= '0;
            desc_q             <= '0;
            qid_q              <= '0;
            bufid_q            <= '0;
        end else begin
            state_q            <= state_d;
            o_descriptor_ready <= ready_d;
            o_queue_wr         <= wr_d;
            ov_queue_waddr     <= waddr_d;
            ov_queue_wdata     <= wdata_d;
            if (state_q == IDLE_S && i_descriptor_wr) begin
                desc_q  <= iv_descriptor;
                qid_q   <= iv_descriptor_qid;
                bufid_q <= iv_descriptor_bufid;
            end
        end
    end

endmodule

// File: tb/tb_network_input_queue.sv
// Table-driven bench for network_input_queue; RAM writes go through a scoreboard queue.
module tb_network_input_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] descriptor;
    logic [2:0]  descriptor_qid;
    logic [8:0]  descriptor_bufid;
    logic        descriptor_wr;
    logic        descriptor_ready;
    logic [56:0] queue_wdata;
    logic [8:0]  queue_waddr;
    logic        queue_wr;
    logic        dequeue;
    logic [2:0]  dequeue_qid;
    logic [8:0]  dequeue_next;
    logic [7:0]  queue_empty;
    logic [71:0] head_ptr;
    logic        dequeue_err;

    always #4 clk = ~clk;

    network_input_queue dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .iv_descriptor       (descriptor),
        .iv_descriptor_qid   (descriptor_qid),
        .iv_descriptor_bufid (descriptor_bufid),
        .i_descriptor_wr     (descriptor_wr),
        .o_descriptor_ready  (descriptor_ready),
        .ov_queue_wdata      (queue_wdata),
        .ov_queue_waddr      (queue_waddr),
        .o_queue_wr          (queue_wr),
        .i_dequeue           (dequeue),
        .iv_dequeue_qid      (dequeue_qid),
        .iv_dequeue_next     (dequeue_next),
        .ov_queue_empty      (queue_empty),
        .ov_head_ptr         (head_ptr),
        .o_dequeue_err       (dequeue_err)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  qid;
        logic [8:0]  bufid;
        logic [47:0] desc;
        logic        deq;
        logic [2:0]  dq;
        logic [8:0]  dnext;
        logic        e_ready;
        logic        e_wr;
        logic [8:0]  e_waddr;
        logic [56:0] e_wdata;
        logic [7:0]  e_empty;
        logic [2:0]  e_hq;
        logic [8:0]  e_head;
        logic        e_err;
    } vec_t;

    localparam int NV = 26;
    vec_t vt [NV];

    logic [65:0] sb [$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic wr, input logic [2:0] qid, input logic [8:0] bufid, input logic [47:0] desc,
        input logic deq, input logic [2:0] dq, input logic [8:0] dnext,
        input logic e_ready, input logic e_wr, input logic [8:0] e_waddr, input logic [56:0] e_wdata,
        input logic [7:0] e_empty, input logic [2:0] e_hq, input logic [8:0] e_head, input logic e_err);
        vec_t v;
        v.wr = wr; v.qid = qid; v.bufid = bufid; v.desc = desc;
        v.deq = deq; v.dq = dq; v.dnext = dnext;
        v.e_ready = e_ready; v.e_wr = e_wr; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
        v.e_empty = e_empty; v.e_hq = e_hq; v.e_head = e_head; v.e_err = e_err;
        return v;
    endfunction

    // RAM write monitor: every strobe must match the oldest expected write.
    always @(posedge clk) begin
        logic [65:0] w;
        #1;
        if (rst_n && queue_wr) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL ram_write_unexpected: got addr %h data %h expected no write at %0t",
                         queue_waddr, queue_wdata, $time);
            end else begin
                w = sb.pop_front();
                chk("ram_waddr", {63'd0, queue_waddr}, {63'd0, w[65:57]});
                chk("ram_wdata", {15'd0, queue_wdata}, {15'd0, w[56:0]});
            end
        end
    end

    initial begin
        logic [8:0] hval;
        // stimulus: wr qid bufid desc | deq dq dnext || ready wr waddr wdata | empty hq head err
        vt[0]  = mk(1, 2, 9'h010, 48'hA5,  0, 0, 9'h0,   0, 0, 9'h0,   57'h0,                  8'hFF, 2, 9'h000, 0);
        vt[1]  = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   0, 1, 9'h010, {9'h000, 48'hA5},       8'hFF, 2, 9'h000, 0);
        vt[2]  = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   1, 0, 9'h0,   57'h0,                  8'hFB, 2, 9'h010, 0);
        vt[3]  = mk(1, 0, 9'h001, 48'h111, 0, 0, 9'h0,   0, 0, 9'h0,   57'h0,                  8'hFB, 0, 9'h000, 0);
        vt[4]  = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   0, 1, 9'h001, {9'h000, 48'h111},      8'hFB, 0, 9'h000, 0);
        vt[5]  = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   1, 0, 9'h0,   57'h0,                  8'hFA, 0, 9'h001, 0);
        vt[6]  = mk(1, 0, 9'h002, 48'h222, 0, 0, 9'h0,   0, 0, 9'h0,   57'h0,                  8'hFA, 0, 9'h001, 0);
        vt[7]  = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   0, 1, 9'h002, {9'h000, 48'h222},      8'hFA, 0, 9'h001, 0);
        vt[8]  = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   1, 1, 9'h001, {9'h002, 48'h111},      8'hFA, 0, 9'h001, 0);
        vt[9]  = mk(1, 0, 9'h003, 48'h333, 0, 0, 9'h0,   0, 0, 9'h0,   57'h0,                  8'hFA, 0, 9'h001, 0);
        vt[10] = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   0, 1, 9'h003, {9'h000, 48'h333},      8'hFA, 0, 9'h001, 0);
        vt[11] = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   1, 1, 9'h002, {9'h003, 48'h222},      8'hFA, 0, 9'h001, 0);
        vt[12] = mk(0, 0, 9'h0,   48'h0,   1, 0, 9'h002, 1, 0, 9'h0,   57'h0,                  8'hFA, 0, 9'h002, 0);
        vt[13] = mk(0, 0, 9'h0,   48'h0,   1, 0, 9'h003, 1, 0, 9'h0,   57'h0,                  8'hFA, 0, 9'h003, 0);
        vt[14] = mk(0, 0, 9'h0,   48'h0,   1, 0, 9'h1AB, 1, 0, 9'h0,   57'h0,                  8'hFB, 0, 9'h003, 0);
        vt[15] = mk(1, 5, 9'h011, 48'h55,  0, 0, 9'h0,   0, 0, 9'h0,   57'h0,                  8'hFB, 5, 9'h000, 0);
        vt[16] = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   0, 1, 9'h011, {9'h000, 48'h55},       8'hFB, 5, 9'h000, 0);
        vt[17] = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   1, 0, 9'h0,   57'h0,                  8'hDB, 5, 9'h011, 0);
        vt[18] = mk(1, 5, 9'h020, 48'h66,  0, 0, 9'h0,   0, 0, 9'h0,   57'h0,                  8'hDB, 5, 9'h011, 0);
        vt[19] = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   0, 1, 9'h020, {9'h000, 48'h66},       8'hDB, 5, 9'h011, 0);
        vt[20] = mk(0, 0, 9'h0,   48'h0,   1, 5, 9'h0AA, 1, 0, 9'h0,   57'h0,                  8'hDB, 5, 9'h020, 0);
        vt[21] = mk(1, 5, 9'h030, 48'h77,  0, 0, 9'h0,   0, 0, 9'h0,   57'h0,                  8'hDB, 5, 9'h020, 0);
        vt[22] = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   0, 1, 9'h030, {9'h000, 48'h77},       8'hDB, 5, 9'h020, 0);
        vt[23] = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   1, 1, 9'h020, {9'h030, 48'h66},       8'hDB, 5, 9'h020, 0);
        vt[24] = mk(0, 0, 9'h0,   48'h0,   1, 7, 9'h055, 1, 0, 9'h0,   57'h0,                  8'hDB, 7, 9'h000, 1);
        vt[25] = mk(0, 0, 9'h0,   48'h0,   0, 0, 9'h0,   1, 0, 9'h0,   57'h0,                  8'hDB, 2, 9'h010, 0);

        rst_n = 1'b0;
        descriptor = '0; descriptor_qid = '0; descriptor_bufid = '0; descriptor_wr = 1'b0;
        dequeue = 1'b0; dequeue_qid = '0; dequeue_next = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {71'd0, descriptor_ready}, 72'd1);
        chk("rst_wr",    {71'd0, queue_wr},         72'd0);
        chk("rst_waddr", {63'd0, queue_waddr},      72'd0);
        chk("rst_wdata", {15'd0, queue_wdata},      72'd0);
        chk("rst_empty", {64'd0, queue_empty},      72'hFF);
        chk("rst_head",  head_ptr,                  72'd0);
        chk("rst_err",   {71'd0, dequeue_err},      72'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            descriptor_wr    = vt[i].wr;
            descriptor_qid   = vt[i].qid;
            descriptor_bufid = vt[i].bufid;
            descriptor       = vt[i].desc;
            dequeue          = vt[i].deq;
            dequeue_qid      = vt[i].dq;
            dequeue_next     = vt[i].dnext;
            if (vt[i].e_wr)
                sb.push_back({vt[i].e_waddr, vt[i].e_wdata});
            @(posedge clk);
            #1;
            hval = head_ptr[vt[i].e_hq*9 +: 9];
            chk($sformatf("v%0d_ready", i), {71'd0, descriptor_ready}, {71'd0, vt[i].e_ready});
            chk($sformatf("v%0d_wr", i),    {71'd0, queue_wr},         {71'd0, vt[i].e_wr});
            chk($sformatf("v%0d_empty", i), {64'd0, queue_empty},      {64'd0, vt[i].e_empty});
            chk($sformatf("v%0d_head%0d", i, vt[i].e_hq), {63'd0, hval}, {63'd0, vt[i].e_head});
            chk($sformatf("v%0d_err", i),   {71'd0, dequeue_err},      {71'd0, vt[i].e_err});
        end

        chk("head_ptr_full", head_ptr, {9'h000, 9'h000, 9'h020, 9'h000, 9'h000, 9'h010, 9'h000, 9'h003});

        // Reset while the accepted descriptor sits in WRITE_S: it must be dropped.
        @(negedge clk);
        descriptor_wr = 1'b1; descriptor_qid = 3'd1; descriptor_bufid = 9'h040; descriptor = 48'h88;
        dequeue = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_accepted", {71'd0, descriptor_ready}, 72'd0);
        descriptor_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {71'd0, descriptor_ready}, 72'd1);
        chk("midrst_wr",    {71'd0, queue_wr},         72'd0);
        chk("midrst_empty", {64'd0, queue_empty},      72'hFF);
        chk("midrst_head",  head_ptr,                  72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst%0d_wr", k),    {71'd0, queue_wr},    72'd0);
            chk($sformatf("postrst%0d_empty", k), {64'd0, queue_empty}, 72'hFF);
        end

        chk("scoreboard_drained", 72'(sb.size()), 72'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
